acc_ctrl: RTL and testbench
===========================

ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of data words.
REQ-002 SHALL have parameter CNT_W, default 4, width of word counters and config counts (max 15 words).
REQ-003 SHALL have parameter TO_W, default 8, width of wait-timeout counter.
REQ-004 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start request, sampled in ST_IDLE only.
- clear_i  in  1  acknowledge DONE / abort a running job.
- cfg_nin_i  in  CNT_W  number of input words.
- cfg_nout_i  in  CNT_W  number of result words.
- cfg_timeout_i  in  TO_W  wait limit in cycles; 0 = no limit.
- buf_raddr_o  out  CNT_W  input-buffer read address.
- buf_rdata_i  in  DATA_W  input-buffer data, combinational from buf_raddr_o.
- dp_wdata_o  out  DATA_W  word to datapath.
- dp_wvalid_o  out  1  write valid.
- dp_wready_i  in  1  write ready.
- dp_start_o  out  1  one-cycle compute start pulse.
- dp_done_i  in  1  datapath compute finished.
- dp_rdata_i  in  DATA_W  result word from datapath.
- dp_rvalid_i  in  1  result valid.
- dp_rready_o  out  1  result ready.
- res_we_o  out  1  result-buffer write enable.
- res_waddr_o  out  CNT_W  result-buffer write address.
- res_wdata_o  out  DATA_W  result-buffer write data.
- status_o  out  4  state code: IDLE 0x0, WRITE 0x1, WAIT 0x2, READ 0x3, DONE 0x4.
- error_o  out  4  error code: OKAY 0x0, INVALID_CFG 0x1, OTHERS 0x2.
- busy_o  out  1  high in WRITE, WAIT, READ.
- irq_o  out  1  one-cycle pulse on entry to DONE.

Function
REQ-005 SHALL implement a registered FSM with states IDLE, WRITE, WAIT, READ, DONE; status_o = registered state code.
REQ-006 SHALL, in IDLE on start_i=1, latch cfg_nin_i, cfg_nout_i, cfg_timeout_i; cfg inputs are ignored at all other times.
REQ-007 SHALL, in IDLE on start_i with cfg_nin_i=0 or cfg_nout_i=0, go to DONE with error_o=0x1 and no datapath activity.
REQ-008 SHALL, in IDLE on start_i with valid cfg, go to WRITE with the write counter at 0 and error_o=0x0.
REQ-009 SHALL, in WRITE, drive buf_raddr_o=wcnt, dp_wdata_o=buf_rdata_i, dp_wvalid_o=1; a transfer occurs only when dp_wvalid_o and dp_wready_i are both 1.
REQ-010 SHALL increment wcnt per transfer; the transfer with wcnt=nin-1 moves to WAIT; dp_wvalid_o SHALL be 0 outside WRITE.
REQ-011 SHALL assert dp_start_o for exactly the first cycle in WAIT.
REQ-012 SHALL, in WAIT, count cycles from 0; dp_done_i=1 moves to READ; if timeout≠0 and count reaches timeout-1 without dp_done_i, move to DONE with error_o=0x2; dp_done_i in the same cycle as expiry wins.
REQ-013 SHALL, in READ, drive dp_rready_o=1; each cycle with dp_rvalid_i=1 SHALL assert res_we_o with res_waddr_o=rcnt, res_wdata_o=dp_rdata_i (combinational) and increment rcnt.
REQ-014 SHALL move from READ to DONE with error_o=0x0 on the transfer with rcnt=nout-1; dp_rready_o and res_we_o SHALL be 0 outside READ.
REQ-015 SHALL assert irq_o one cycle, registered, on entry to DONE for any error code.
REQ-016 SHALL hold DONE and error_o until clear_i=1, then go to IDLE with error_o=0x0; start_i in DONE is ignored, also when concurrent with clear_i.
REQ-017 SHALL, on clear_i in WRITE, WAIT or READ, abort to IDLE next cycle, error_o=0x0, no irq_o, counters cleared.
REQ-018 SHALL ignore dp_done_i outside WAIT and dp_rvalid_i outside READ.

Reset
REQ-019 SHALL, on rst=1 asynchronously, force state IDLE, all counters 0, latched cfg 0, and all outputs 0 (status_o=0x0, error_o=0x0, buf_raddr_o=0, res_waddr_o=0); reset mid-job discards it without irq_o.

Verification
REQ-020 nin=3, nout=2, timeout=0, wready=1, done 5 cycles after start, rvalid 2 cycles -> 3 writes at addr 0,1,2; dp_start_o 1 cycle; res_we at addr 0,1; DONE, error 0x0, one irq_o.
REQ-021 nin=2 with wready toggling 1,0,1 -> wcnt advances only on ready cycles, dp_wdata_o stable while stalled, WAIT entered after 2nd transfer.
REQ-022 nin=0, nout=4, start -> DONE next cycle, error_o=0x1, irq_o pulse, no wvalid/start; clear_i -> IDLE, error 0x0.
REQ-023 timeout=4, dp_done_i never -> DONE after 4 WAIT cycles, error_o=0x2; repeat with dp_done_i on 4th cycle -> READ.
REQ-024 clear_i in READ after 1 of 3 results -> IDLE next cycle, no irq_o; rst asserted in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/acc_ctrl.sv
// Accelerator job controller: streams nin input words to a datapath, starts it,
// waits for completion (optionally bounded), and collects nout result words.
module acc_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [CNT_W-1:0]  cfg_nin_i,
    input  logic [CNT_W-1:0]  cfg_nout_i,
    input  logic [TO_W-1:0]   cfg_timeout_i,
    output logic [CNT_W-1:0]  buf_raddr_o,
    input  logic [DATA_W-1:0] buf_rdata_i,
    output logic [DATA_W-1:0] dp_wdata_o,
    output logic              dp_wvalid_o,
    input  logic              dp_wready_i,
    output logic              dp_start_o,
    input  logic              dp_done_i,
    input  logic [DATA_W-1:0] dp_rdata_i,
    input  logic              dp_rvalid_i,
    output logic              dp_rready_o,
    output logic              res_we_o,
    output logic [CNT_W-1:0]  res_waddr_o,
    output logic [DATA_W-1:0] res_wdata_o,
    output logic [3:0]        status_o,
    output logic [3:0]        error_o,
    output logic              busy_o,
    output logic              irq_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] ERR_OKAY    = 4'h0;
    localparam logic [3:0] ERR_INV_CFG = 4'h1;
    localparam logic [3:0] ERR_OTHERS  = 4'h2;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  nin_q, nin_d;
    logic [CNT_W-1:0]  nout_q, nout_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [3:0]        err_q, err_d;
    logic              start_q;
    logic              irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            nin_q   <= '0;
            nout_q  <= '0;
            to_q    <= '0;
            err_q   <= ERR_OKAY;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            nin_q   <= nin_d;
            nout_q  <= nout_d;
            to_q    <= to_d;
            err_q   <= err_d;
            // Both pulses fire only on the edge that enters their state.
            start_q <= (state_d == ST_WAIT) && (state_q != ST_WAIT);
            irq_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        tcnt_d      = tcnt_q;
        nin_d       = nin_q;
        nout_d      = nout_q;
        to_d        = to_q;
        err_d       = err_q;
        dp_wvalid_o = 1'b0;
        dp_wdata_o  = '0;
        dp_rready_o = 1'b0;
        res_we_o    = 1'b0;
        res_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nin_d  = cfg_nin_i;
                    nout_d = cfg_nout_i;
                    to_d   = cfg_timeout_i;
                    wcnt_d = '0;
                    if (cfg_nin_i == '0 || cfg_nout_i == '0) begin
                        state_d = ST_DONE;
                        err_d   = ERR_INV_CFG;
                    end else begin
                        state_d = ST_WRITE;
                        err_d   = ERR_OKAY;
                    end
                end
            end
            ST_WRITE: begin
                dp_wvalid_o = 1'b1;
                dp_wdata_o  = buf_rdata_i;
                if (clear_i) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                    err_d   = ERR_OKAY;
                end else if (dp_wready_i) begin
                    if (wcnt_q == nin_q - 1'b1) begin
                        state_d = ST_WAIT;
                        wcnt_d  = '0;
                        tcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (clear_i) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                    err_d   = ERR_OKAY;
                end else if (dp_done_i) begin
                    state_d = ST_READ;
                    tcnt_d  = '0;
                    rcnt_d  = '0;
                end else if (to_q != '0 && tcnt_q == to_q - 1'b1) begin
                    state_d = ST_DONE;
                    tcnt_d  = '0;
                    err_d   = ERR_OTHERS;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_READ: begin
                dp_rready_o = 1'b1;
                if (dp_rvalid_i) begin
                    res_we_o    = 1'b1;
                    res_wdata_o = dp_rdata_i;
                end
                if (clear_i) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                    err_d   = ERR_OKAY;
                end else if (dp_rvalid_i) begin
                    if (rcnt_q == nout_q - 1'b1) begin
                        state_d = ST_DONE;
                        rcnt_d  = '0;
                        err_d   = ERR_OKAY;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_OKAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign buf_raddr_o = wcnt_q;
    assign res_waddr_o = rcnt_q;
    assign dp_start_o  = start_q;
    assign irq_o       = irq_q;
    assign error_o     = err_q;
    assign status_o    = {1'b0, state_q};
    assign busy_o      = (state_q == ST_WRITE) || (state_q == ST_WAIT) || (state_q == ST_READ);

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: a cycle table for a full job plus directed corner sequences.
module tb_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, clear_i;
    logic [3:0]  cfg_nin_i, cfg_nout_i;
    logic [7:0]  cfg_timeout_i;
    logic [3:0]  buf_raddr_o;
    logic [31:0] buf_rdata_i;
    logic [31:0] dp_wdata_o;
    logic        dp_wvalid_o, dp_wready_i, dp_start_o, dp_done_i;
    logic [31:0] dp_rdata_i;
    logic        dp_rvalid_i, dp_rready_o, res_we_o;
    logic [3:0]  res_waddr_o;
    logic [31:0] res_wdata_o;
    logic [3:0]  status_o, error_o;
    logic        busy_o, irq_o;

    int errors = 0;
    int checks = 0;

    acc_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
        .cfg_nin_i(cfg_nin_i), .cfg_nout_i(cfg_nout_i), .cfg_timeout_i(cfg_timeout_i),
        .buf_raddr_o(buf_raddr_o), .buf_rdata_i(buf_rdata_i),
        .dp_wdata_o(dp_wdata_o), .dp_wvalid_o(dp_wvalid_o), .dp_wready_i(dp_wready_i),
        .dp_start_o(dp_start_o), .dp_done_i(dp_done_i),
        .dp_rdata_i(dp_rdata_i), .dp_rvalid_i(dp_rvalid_i), .dp_rready_o(dp_rready_o),
        .res_we_o(res_we_o), .res_waddr_o(res_waddr_o), .res_wdata_o(res_wdata_o),
        .status_o(status_o), .error_o(error_o), .busy_o(busy_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Input buffer model: word at address a is 0xA000 + a.
    assign buf_rdata_i = 32'hA000 + {28'h0, buf_raddr_o};

    // in  = {start, clear, wready, done, rvalid}
    // flg = {wvalid, dp_start, rready, res_we, irq, busy}
    typedef struct packed {
        logic [4:0] in;
        logic [7:0] rdata;
        logic [3:0] st;
        logic [3:0] ra;
        logic [3:0] wa;
        logic [3:0] err;
        logic [5:0] flg;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle before checks.
    task automatic cyc(input logic [4:0] in, input logic [7:0] rd);
        @(negedge clk);
        {start_i, clear_i, dp_wready_i, dp_done_i, dp_rvalid_i} = in;
        dp_rdata_i = {24'h0, rd};
        #1;
    endtask

    function automatic logic [5:0] flags();
        return {dp_wvalid_o, dp_start_o, dp_rready_o, res_we_o, irq_o, busy_o};
    endfunction

    task automatic set_cfg(input logic [3:0] nin, input logic [3:0] nout, input logic [7:0] to);
        cfg_nin_i = nin;
        cfg_nout_i = nout;
        cfg_timeout_i = to;
    endtask

    initial begin
        vt[0]  = '{5'b10000, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 6'b000000};
        vt[1]  = '{5'b00100, 8'h00, 4'h1, 4'h0, 4'h0, 4'h0, 6'b100001};
        vt[2]  = '{5'b00110, 8'h00, 4'h1, 4'h1, 4'h0, 4'h0, 6'b100001};
        vt[3]  = '{5'b00100, 8'h00, 4'h1, 4'h2, 4'h0, 4'h0, 6'b100001};
        vt[4]  = '{5'b00000, 8'h00, 4'h2, 4'h0, 4'h0, 4'h0, 6'b010001};
        vt[5]  = '{5'b00000, 8'h00, 4'h2, 4'h0, 4'h0, 4'h0, 6'b000001};
        vt[6]  = '{5'b00001, 8'h55, 4'h2, 4'h0, 4'h0, 4'h0, 6'b000001};
        vt[7]  = '{5'b00000, 8'h00, 4'h2, 4'h0, 4'h0, 4'h0, 6'b000001};
        vt[8]  = '{5'b00000, 8'h00, 4'h2, 4'h0, 4'h0, 4'h0, 6'b000001};
        vt[9]  = '{5'b00010, 8'h00, 4'h2, 4'h0, 4'h0, 4'h0, 6'b000001};
        vt[10] = '{5'b00001, 8'h11, 4'h3, 4'h0, 4'h0, 4'h0, 6'b001101};
        vt[11] = '{5'b00000, 8'h00, 4'h3, 4'h0, 4'h1, 4'h0, 6'b001001};
        vt[12] = '{5'b00001, 8'h22, 4'h3, 4'h0, 4'h1, 4'h0, 6'b001101};
        vt[13] = '{5'b00000, 8'h00, 4'h4, 4'h0, 4'h0, 4'h0, 6'b000010};
        vt[14] = '{5'b10000, 8'h00, 4'h4, 4'h0, 4'h0, 4'h0, 6'b000000};
        vt[15] = '{5'b11000, 8'h00, 4'h4, 4'h0, 4'h0, 4'h0, 6'b000000};
        vt[16] = '{5'b00000, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 6'b000000};

        rst = 1'b1;
        {start_i, clear_i, dp_wready_i, dp_done_i, dp_rvalid_i} = 5'b0;
        dp_rdata_i = 32'h0;
        set_cfg(4'd3, 4'd2, 8'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_status", 32'(status_o), 32'h0);
        chk("rst_error", 32'(error_o), 32'h0);
        chk("rst_flags", 32'(flags()), 32'h0);
        chk("rst_raddr", 32'(buf_raddr_o), 32'h0);
        chk("rst_waddr", 32'(res_waddr_o), 32'h0);
        chk("rst_wdata", dp_wdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full job: nin=3, nout=2, no timeout; cfg changes after latch must not matter.
        for (int i = 0; i < 17; i++) begin
            cyc(vt[i].in, vt[i].rdata);
            if (i == 1) set_cfg(4'd1, 4'd1, 8'd1);
            chk($sformatf("v%0d_status", i), 32'(status_o), 32'(vt[i].st));
            chk($sformatf("v%0d_raddr", i), 32'(buf_raddr_o), 32'(vt[i].ra));
            chk($sformatf("v%0d_waddr", i), 32'(res_waddr_o), 32'(vt[i].wa));
            chk($sformatf("v%0d_error", i), 32'(error_o), 32'(vt[i].err));
            chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(vt[i].flg));
            chk($sformatf("v%0d_wdata", i), dp_wdata_o,
                vt[i].flg[5] ? 32'hA000 + 32'(vt[i].ra) : 32'h0);
            chk($sformatf("v%0d_reswdata", i), res_wdata_o,
                vt[i].flg[2] ? {24'h0, vt[i].rdata} : 32'h0);
        end

        // Write stall: nin=2, wready 1,0,0,1.
        set_cfg(4'd2, 4'd1, 8'd0);
        cyc(5'b10000, 8'h0);
        cyc(5'b00100, 8'h0);
        chk("stall_raddr0", 32'(buf_raddr_o), 32'h0);
        chk("stall_wdata0", dp_wdata_o, 32'hA000);
        cyc(5'b00000, 8'h0);
        chk("stall_raddr1", 32'(buf_raddr_o), 32'h1);
        chk("stall_wdata1", dp_wdata_o, 32'hA001);
        cyc(5'b00000, 8'h0);
        chk("stall_hold_raddr", 32'(buf_raddr_o), 32'h1);
        chk("stall_hold_wdata", dp_wdata_o, 32'hA001);
        chk("stall_hold_status", 32'(status_o), 32'h1);
        cyc(5'b00100, 8'h0);
        chk("stall_last_wvalid", 32'(dp_wvalid_o), 32'h1);
        cyc(5'b00000, 8'h0);
        chk("stall_wait_status", 32'(status_o), 32'h2);
        chk("stall_dp_start", 32'(dp_start_o), 32'h1);
        cyc(5'b00010, 8'h0);
        cyc(5'b00001, 8'h77);
        chk("stall_res_we", 32'(res_we_o), 32'h1);
        chk("stall_res_wdata", res_wdata_o, 32'h77);
        cyc(5'b00000, 8'h0);
        chk("stall_done", 32'(status_o), 32'h4);
        chk("stall_irq", 32'(irq_o), 32'h1);
        cyc(5'b01000, 8'h0);

        // Invalid configuration: nin=0.
        set_cfg(4'd0, 4'd4, 8'd0);
        cyc(5'b10000, 8'h0);
        cyc(5'b00100, 8'h0);
        chk("inv_status", 32'(status_o), 32'h4);
        chk("inv_error", 32'(error_o), 32'h1);
        chk("inv_flags", 32'(flags()), 32'b000010);
        cyc(5'b00000, 8'h0);
        chk("inv_irq_once", 32'(irq_o), 32'h0);
        chk("inv_error_hold", 32'(error_o), 32'h1);
        cyc(5'b01000, 8'h0);
        cyc(5'b00000, 8'h0);
        chk("inv_cleared_status", 32'(status_o), 32'h0);
        chk("inv_cleared_error", 32'(error_o), 32'h0);

        // Timeout=4 with no done.
        set_cfg(4'd1, 4'd1, 8'd4);
        cyc(5'b10000, 8'h0);
        cyc(5'b00100, 8'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(5'b00000, 8'h0);
            chk($sformatf("to_wait%0d_status", k), 32'(status_o), 32'h2);
            chk($sformatf("to_wait%0d_start", k), 32'(dp_start_o), (k == 0) ? 32'h1 : 32'h0);
        end
        cyc(5'b00000, 8'h0);
        chk("to_status", 32'(status_o), 32'h4);
        chk("to_error", 32'(error_o), 32'h2);
        chk("to_irq", 32'(irq_o), 32'h1);
        cyc(5'b01000, 8'h0);

        // Timeout=4 with done on the expiry cycle.
        cyc(5'b10000, 8'h0);
        cyc(5'b00100, 8'h0);
        for (int k = 0; k < 3; k++) cyc(5'b00000, 8'h0);
        cyc(5'b00010, 8'h0);
        chk("tod_last_wait", 32'(status_o), 32'h2);
        cyc(5'b00000, 8'h0);
        chk("tod_read", 32'(status_o), 32'h3);
        chk("tod_error", 32'(error_o), 32'h0);
        cyc(5'b00001, 8'h33);
        cyc(5'b00000, 8'h0);
        chk("tod_done_error", 32'(error_o), 32'h0);
        chk("tod_done_status", 32'(status_o), 32'h4);
        cyc(5'b01000, 8'h0);

        // Abort in READ after 1 of 3 results.
        set_cfg(4'd1, 4'd3, 8'd0);
        cyc(5'b10000, 8'h0);
        cyc(5'b00100, 8'h0);
        cyc(5'b00010, 8'h0);
        cyc(5'b00001, 8'h44);
        chk("abort_first_we", 32'(res_we_o), 32'h1);
        cyc(5'b01000, 8'h0);
        chk("abort_status_pre", 32'(status_o), 32'h3);
        cyc(5'b00000, 8'h0);
        chk("abort_status", 32'(status_o), 32'h0);
        chk("abort_flags", 32'(flags()), 32'h0);
        chk("abort_waddr", 32'(res_waddr_o), 32'h0);
        cyc(5'b00000, 8'h0);
        chk("abort_no_irq", 32'(irq_o), 32'h0);

        // Reset in WAIT clears outputs without waiting for a clock.
        cyc(5'b10000, 8'h0);
        cyc(5'b00100, 8'h0);
        cyc(5'b00000, 8'h0);
        chk("rw_pre_start", 32'(dp_start_o), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rw_status", 32'(status_o), 32'h0);
        chk("rw_flags", 32'(flags()), 32'h0);
        chk("rw_error", 32'(error_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(5'b00000, 8'h0);
        chk("rw_after_status", 32'(status_o), 32'h0);
        chk("rw_after_irq", 32'(irq_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
